instruction_fetch_unit: RTL and testbench

- Consumer of the program counter's output value.
- Captures the current PC value, runs a req/ack read on the instruction memory port, and latches the returned word as the instruction.
- Hands the instruction to decode with a valid/ready handshake.
- Drives the PC's inc input as a one-cycle pulse after each successful fetch.
- Sits between the program counter, the memory interface and the control unit.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_timeout_counter.sv | 47 ++++
 rtl/instruction_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - fetch FSM state encoding
//   - default NOP instruction word loaded on reset, flush and fault
//   - default REQ timeout length (only meaningful with FETCH_TIMEOUT_EN)
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT      = 32'h0000_0000;
    localparam int          TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/fetch_timeout_counter.sv
// REQ-phase watchdog for the fetch unit. Only instantiated when
// FETCH_TIMEOUT_EN is defined.
//   clock   in  rising-edge clock
//   clear   in  asynchronous active-high reset
//   start   in  restart the count (REQ entry)
//   run     in  one REQ cycle elapsed without ack
//   expired out this REQ cycle is the LIMIT-th one without ack
module fetch_timeout_counter
    import fetch_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic run,
    output logic expired
);

    localparam int CW = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q holds the number of earlier ack-less REQ cycles, so the
    // LIMIT-th such cycle is the one that sees cnt_q == LIMIT-1.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = run && (cnt_q == LAST);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: captures the PC, performs a req/ack read on the
// instruction memory, latches the word and offers it to decode with a
// valid/ready handshake. Emits a one-cycle pc_inc pulse per delivered
// instruction. Optional REQ timeout with sticky fault: FETCH_TIMEOUT_EN.
//   clock, clear                 clock and async active-high reset
//   pc_in, fetch_start, flush    PC value and control requests
//   mem_addr, mem_rd_req         memory read request (registered)
//   mem_rd_ack, mem_rd_data      memory response, data valid with ack
//   ir_out, ir_valid, ir_ready   instruction handoff to decode
//   pc_inc                       increment pulse to the program counter
//   busy, fetch_fault            status
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no fetch in progress, waiting for fetch_start
// ST_REQ   | mem_rd_req asserted, waiting for mem_rd_ack
// ST_VALID | ir_out holds an instruction not yet accepted by decode
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR      = DATA_WIDTH'(NOP_INSTR_DEFAULT),
    parameter int                    TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  fetch_start,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_req,
    input  logic                  mem_rd_ack,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] ir_out,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic                  pc_inc,
    output logic                  busy,
    output logic                  fetch_fault
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  valid_q, valid_d;
    logic                  inc_q, inc_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  timed_out;
    logic                  fault_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        req_d        = req_q;
        ir_d         = ir_q;
        valid_d      = valid_q;
        inc_d        = 1'b0;
        flush_pend_d = flush_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_start && !flush && !fault_q) begin
                    addr_d  = pc_in;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A flush never aborts the bus handshake; it only marks the
                // returning word for discard.
                if (mem_rd_ack) begin
                    req_d        = 1'b0;
                    flush_pend_d = 1'b0;
                    if (flush_pend_q || flush) begin
                        ir_d    = NOP_INSTR;
                        state_d = ST_IDLE;
                    end else begin
                        ir_d    = mem_rd_data;
                        valid_d = 1'b1;
                        inc_d   = 1'b1;
                        state_d = ST_VALID;
                    end
                end else if (timed_out) begin
                    req_d        = 1'b0;
                    flush_pend_d = 1'b0;
                    ir_d         = NOP_INSTR;
                    state_d      = ST_IDLE;
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            ST_VALID: begin
                if (flush) begin
                    valid_d = 1'b0;
                    ir_d    = NOP_INSTR;
                    state_d = ST_IDLE;
                end else if (ir_ready) begin
                    valid_d = 1'b0;
                    // pc_inc fired when this word arrived, so pc_in already
                    // points at the next instruction.
                    if (fetch_start) begin
                        addr_d  = pc_in;
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            req_q        <= 1'b0;
            ir_q         <= NOP_INSTR;
            valid_q      <= 1'b0;
            inc_q        <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            ir_q         <= ir_d;
            valid_q      <= valid_d;
            inc_q        <= inc_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic tmo_start;
    logic tmo_run;

    assign tmo_start = (state_d == ST_REQ) && (state_q != ST_REQ);
    assign tmo_run   = (state_q == ST_REQ) && !mem_rd_ack;

    fetch_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .clear   (clear),
        .start   (tmo_start),
        .run     (tmo_run),
        .expired (timed_out)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_q | timed_out;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timed_out          = 1'b0;
    assign fault_q            = 1'b0;
`endif

    assign mem_addr    = addr_q;
    assign mem_rd_req  = req_q;
    assign ir_out      = ir_q;
    assign ir_valid    = valid_q;
    assign pc_inc      = inc_q;
    assign busy        = (state_q != ST_IDLE);
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Built with TIMEOUT_CYCLES=4 so
// the timeout scenario is short when FETCH_TIMEOUT_EN is defined.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] pc_in;
    logic        fetch_start;
    logic        flush;
    logic [31:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_rd_ack;
    logic [31:0] mem_rd_data;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        pc_inc;
    logic        busy;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    int   inc_count    = 0;
    int   inc_adjacent = 0;
    logic inc_prev     = 1'b0;

    instruction_fetch_unit #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .NOP_INSTR      (32'h0),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .pc_in       (pc_in),
        .fetch_start (fetch_start),
        .flush       (flush),
        .mem_addr    (mem_addr),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .ir_out      (ir_out),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .pc_inc      (pc_inc),
        .busy        (busy),
        .fetch_fault (fetch_fault)
    );

    always #5 clock = ~clock;

    // pc_inc pulse bookkeeping, sampled mid-cycle
    always @(negedge clock) begin
        if (pc_inc) inc_count++;
        if (pc_inc && inc_prev) inc_adjacent++;
        inc_prev = pc_inc;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        total++; if (mem_rd_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_rd_req); end
        total++; if (ir_out !== 32'h0) begin bad++; $display("FAIL reset_ir: got %h want 00000000", ir_out); end
        total++; if ({ir_valid, busy, pc_inc, fetch_fault} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {ir_valid, busy, pc_inc, fetch_fault}); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000000", mem_addr); end
        pc_in = 32'h44; fetch_start = 1'b1;
        cyc();
        fetch_start = 1'b0;
        total++; if ({mem_rd_req, busy} !== 2'b11) begin bad++; $display("FAIL reset_pre_req: got %b want 11", {mem_rd_req, busy}); end
        #2 clear = 1'b1;
        #1;
        total++; if (mem_rd_req !== 1'b0) begin bad++; $display("FAIL reset_async_req: got %b want 0", mem_rd_req); end
        total++; if ({ir_valid, busy} !== 2'b00) begin bad++; $display("FAIL reset_async_flags: got %b want 00", {ir_valid, busy}); end
        total++; if (ir_out !== 32'h0) begin bad++; $display("FAIL reset_async_ir: got %h want 00000000", ir_out); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_async_addr: got %h want 00000000", mem_addr); end
        cyc();
        clear = 1'b0;
        cyc();
        total++; if ({mem_rd_req, busy} !== 2'b00) begin bad++; $display("FAIL reset_after: got %b want 00", {mem_rd_req, busy}); end
    endtask

    task automatic test_single_fetch();
        int base;
        base = inc_count;
        pc_in = 32'h10; fetch_start = 1'b1;
        cyc();
        fetch_start = 1'b0;
        pc_in = 32'h99;
        for (int i = 0; i < 3; i++) begin
            total++; if ({mem_rd_req, mem_addr} !== {1'b1, 32'h10}) begin bad++; $display("FAIL single_req_c%0d: got req=%b addr=%h want req=1 addr=00000010", i + 1, mem_rd_req, mem_addr); end
            total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid_c%0d: got %b want 0", i + 1, ir_valid); end
            if (i == 2) begin
                mem_rd_ack = 1'b1; mem_rd_data = 32'hA5A5_0001;
            end
            cyc();
        end
        mem_rd_ack = 1'b0; mem_rd_data = 32'h0;
        total++; if ({ir_valid, ir_out} !== {1'b1, 32'hA5A5_0001}) begin bad++; $display("FAIL single_ir: got valid=%b ir=%h want valid=1 ir=a5a50001", ir_valid, ir_out); end
        total++; if ({pc_inc, mem_rd_req, busy} !== 3'b101) begin bad++; $display("FAIL single_pulse: got inc/req/busy=%b want 101", {pc_inc, mem_rd_req, busy}); end
        cyc();
        total++; if ({pc_inc, ir_valid} !== 2'b01) begin bad++; $display("FAIL single_hold: got inc/valid=%b want 01", {pc_inc, ir_valid}); end
        ir_ready = 1'b1;
        cyc();
        ir_ready = 1'b0;
        total++; if ({ir_valid, busy} !== 2'b00) begin bad++; $display("FAIL single_retire: got valid/busy=%b want 00", {ir_valid, busy}); end
        total++; if (inc_count - base !== 1) begin bad++; $display("FAIL single_inc_count: got %0d want 1", inc_count - base); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = inc_count;
        inc_adjacent = 0;
        pc_in = 32'h20; fetch_start = 1'b1;
        cyc();
        fetch_start = 1'b0;
        mem_rd_ack = 1'b1; mem_rd_data = 32'h0000_D001;
        cyc();
        mem_rd_ack = 1'b0;
        total++; if ({ir_valid, pc_inc, ir_out} !== {2'b11, 32'h0000_D001}) begin bad++; $display("FAIL b2b_first: got valid=%b inc=%b ir=%h want 1 1 0000d001", ir_valid, pc_inc, ir_out); end
        ir_ready = 1'b1; fetch_start = 1'b1; pc_in = 32'h11;
        cyc();
        ir_ready = 1'b0; fetch_start = 1'b0;
        total++; if ({mem_rd_req, mem_addr} !== {1'b1, 32'h11}) begin bad++; $display("FAIL b2b_req: got req=%b addr=%h want req=1 addr=00000011", mem_rd_req, mem_addr); end
        total++; if ({ir_valid, pc_inc} !== 2'b00) begin bad++; $display("FAIL b2b_gap: got valid/inc=%b want 00", {ir_valid, pc_inc}); end
        mem_rd_ack = 1'b1; mem_rd_data = 32'h0000_D002;
        cyc();
        mem_rd_ack = 1'b0;
        total++; if ({ir_valid, pc_inc, ir_out} !== {2'b11, 32'h0000_D002}) begin bad++; $display("FAIL b2b_second: got valid=%b inc=%b ir=%h want 1 1 0000d002", ir_valid, pc_inc, ir_out); end
        ir_ready = 1'b1;
        cyc();
        ir_ready = 1'b0;
        cyc();
        total++; if (inc_count - base !== 2) begin bad++; $display("FAIL b2b_inc_count: got %0d want 2", inc_count - base); end
        total++; if (inc_adjacent !== 0) begin bad++; $display("FAIL b2b_inc_adjacent: got %0d want 0", inc_adjacent); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_flush_req();
        int base;
        base = inc_count;
        pc_in = 32'h30; fetch_start = 1'b1;
        cyc();
        fetch_start = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        total++; if ({mem_rd_req, mem_addr} !== {1'b1, 32'h30}) begin bad++; $display("FAIL flushreq_no_abort: got req=%b addr=%h want req=1 addr=00000030", mem_rd_req, mem_addr); end
        mem_rd_ack = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
        cyc();
        mem_rd_ack = 1'b0;
        total++; if ({ir_valid, pc_inc, mem_rd_req, busy} !== 4'b0000) begin bad++; $display("FAIL flushreq_flags: got valid/inc/req/busy=%b want 0000", {ir_valid, pc_inc, mem_rd_req, busy}); end
        total++; if (ir_out !== 32'h0) begin bad++; $display("FAIL flushreq_ir: got %h want 00000000", ir_out); end
        cyc();
        total++; if (inc_count - base !== 0) begin bad++; $display("FAIL flushreq_inc_count: got %0d want 0", inc_count - base); end
        // pending flush must not leak into the next fetch
        pc_in = 32'h34; fetch_start = 1'b1;
        cyc();
        fetch_start = 1'b0;
        mem_rd_ack = 1'b1; mem_rd_data = 32'h0000_1234;
        cyc();
        mem_rd_ack = 1'b0;
        total++; if ({ir_valid, pc_inc, ir_out} !== {2'b11, 32'h0000_1234}) begin bad++; $display("FAIL flushreq_next: got valid=%b inc=%b ir=%h want 1 1 00001234", ir_valid, pc_inc, ir_out); end
        ir_ready = 1'b1;
        cyc();
        ir_ready = 1'b0;
    endtask

    task automatic test_stall_flush();
        pc_in = 32'h40; fetch_start = 1'b1;
        cyc();
        fetch_start = 1'b0;
        mem_rd_ack = 1'b1; mem_rd_data = 32'hCAFE_0001;
        cyc();
        mem_rd_ack = 1'b0; mem_rd_data = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            total++; if ({ir_valid, ir_out} !== {1'b1, 32'hCAFE_0001}) begin bad++; $display("FAIL stall_hold_%0d: got valid=%b ir=%h want valid=1 ir=cafe0001", i, ir_valid, ir_out); end
            cyc();
        end
        flush = 1'b1; ir_ready = 1'b1;
        cyc();
        flush = 1'b0; ir_ready = 1'b0;
        total++; if ({ir_valid, pc_inc, busy} !== 3'b000) begin bad++; $display("FAIL stall_flush_flags: got valid/inc/busy=%b want 000", {ir_valid, pc_inc, busy}); end
        total++; if (ir_out !== 32'h0) begin bad++; $display("FAIL stall_flush_ir: got %h want 00000000", ir_out); end
        // flush together with fetch_start in IDLE: no fetch is started
        flush = 1'b1; fetch_start = 1'b1; pc_in = 32'h48;
        cyc();
        flush = 1'b0; fetch_start = 1'b0;
        total++; if ({mem_rd_req, busy} !== 2'b00) begin bad++; $display("FAIL idle_flush_start: got req/busy=%b want 00", {mem_rd_req, busy}); end
    endtask

    task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
        pc_in = 32'h50; fetch_start = 1'b1;
        cyc();
        fetch_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if ({mem_rd_req, fetch_fault} !== 2'b10) begin bad++; $display("FAIL tmo_req_c%0d: got req/fault=%b want 10", i + 1, {mem_rd_req, fetch_fault}); end
            cyc();
        end
        total++; if ({mem_rd_req, fetch_fault, busy, pc_inc} !== 4'b0100) begin bad++; $display("FAIL tmo_expire: got req/fault/busy/inc=%b want 0100", {mem_rd_req, fetch_fault, busy, pc_inc}); end
        total++; if (ir_out !== 32'h0) begin bad++; $display("FAIL tmo_ir: got %h want 00000000", ir_out); end
        fetch_start = 1'b1;
        cyc();
        cyc();
        fetch_start = 1'b0;
        total++; if ({mem_rd_req, busy, fetch_fault} !== 3'b001) begin bad++; $display("FAIL tmo_sticky: got req/busy/fault=%b want 001", {mem_rd_req, busy, fetch_fault}); end
        #2 clear = 1'b1;
        #1 clear = 1'b0;
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b want 0", fetch_fault); end
        cyc();
`else
        pc_in = 32'h50; fetch_start = 1'b1;
        cyc();
        fetch_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++; if ({mem_rd_req, fetch_fault} !== 2'b10) begin bad++; $display("FAIL notmo_wait_c%0d: got req/fault=%b want 10", i + 1, {mem_rd_req, fetch_fault}); end
            cyc();
        end
        mem_rd_ack = 1'b1; mem_rd_data = 32'h0000_0050;
        cyc();
        mem_rd_ack = 1'b0;
        total++; if ({ir_valid, ir_out, fetch_fault} !== {1'b1, 32'h0000_0050, 1'b0}) begin bad++; $display("FAIL notmo_late_ack: got valid=%b ir=%h fault=%b want 1 00000050 0", ir_valid, ir_out, fetch_fault); end
        ir_ready = 1'b1;
        cyc();
        ir_ready = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear = 1'b1;
        pc_in = 32'h0; fetch_start = 1'b0; flush = 1'b0;
        mem_rd_ack = 1'b0; mem_rd_data = 32'h0; ir_ready = 1'b0;
        cyc();
        cyc();
        clear = 1'b0;
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_flush_req();
        test_stall_flush();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
